// File: rtl/operand_loader.sv
// Operand loader: synchronizes and debounces a push button, then shifts four hex nibbles
// into a 16-bit operand offered to the accumulator with a valid/ready handshake.
// Build option: define LOADER_DEBOUNCE_EN to include the button debouncer.
module operand_loader #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic        Clk,
  input  logic        Reset_Clear,
  input  logic        Enter,
  input  logic [3:0]  SW,
  input  logic        Cancel,
  input  logic        Ready,
  output logic [15:0] Data_Out,
  output logic        Valid,
  output logic [15:0] Entry,
  output logic [2:0]  Digit_Cnt
);

  // state   | meaning
  // COLLECT | shifting nibbles into Entry on each press
  // OFFER   | Data_Out held with Valid high until Ready
  typedef enum logic {
    COLLECT = 1'b0,
    OFFER   = 1'b1
  } state_t;

  state_t state, state_next;

  logic        sync_1, sync_2;
  logic        level, level_next;
  logic [1:0]  fill;
  logic        armed;
  logic        press;

  logic [15:0] entry_next;
  logic [2:0]  cnt_next;
  logic [15:0] data_next;
  logic        valid_next;

  always_ff @(posedge Clk or negedge Reset_Clear) begin
    if (!Reset_Clear) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= Enter;
      sync_2 <= sync_1;
    end
  end

  // A button held through reset must be seen released before any press counts;
  // fill masks the synchronizer's reset value until real samples have arrived.
  always_ff @(posedge Clk or negedge Reset_Clear) begin
    if (!Reset_Clear) begin
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      fill <= {fill[0], 1'b1};
      if (fill[1] && sync_2) begin
        armed <= 1'b1;
      end
    end
  end

`ifdef LOADER_DEBOUNCE_EN
  logic [15:0] db_cnt, db_cnt_next;

  always_comb begin
    db_cnt_next = '0;
    level_next  = level;
    if (sync_2 != level) begin
      if (db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
        level_next = sync_2;
      end else begin
        db_cnt_next = db_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_Clear) begin
    if (!Reset_Clear) begin
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt_next;
    end
  end
`else
  logic [15:0] unused_debounce;
  assign unused_debounce = DEBOUNCE_CYCLES;
  assign level_next      = sync_2;
`endif

  always_ff @(posedge Clk or negedge Reset_Clear) begin
    if (!Reset_Clear) begin
      level <= 1'b1;
    end else begin
      level <= level_next;
    end
  end

  // Pulse in the cycle the accepted level is about to fall.
  assign press = armed && level && !level_next;

  always_ff @(posedge Clk or negedge Reset_Clear) begin
    if (!Reset_Clear) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    entry_next = Entry;
    cnt_next   = Digit_Cnt;
    data_next  = Data_Out;
    valid_next = Valid;
    case (state)
      COLLECT: begin
        if (Cancel) begin
          entry_next = '0;
          cnt_next   = '0;
        end else if (press) begin
          entry_next = {Entry[11:0], SW};
          cnt_next   = Digit_Cnt + 3'd1;
          if (Digit_Cnt == 3'd3) begin
            data_next  = {Entry[11:0], SW};
            valid_next = 1'b1;
            state_next = OFFER;
          end
        end
      end
      OFFER: begin
        if (Valid && Ready) begin
          valid_next = 1'b0;
          entry_next = '0;
          cnt_next   = '0;
          state_next = COLLECT;
        end
      end
      default: begin
        state_next = COLLECT;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_Clear) begin
    if (!Reset_Clear) begin
      Entry     <= '0;
      Digit_Cnt <= '0;
      Data_Out  <= '0;
      Valid     <= 1'b0;
    end else begin
      Entry     <= entry_next;
      Digit_Cnt <= cnt_next;
      Data_Out  <= data_next;
      Valid     <= valid_next;
    end
  end

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: stimulus pushes expected output changes with their
// expected cycle; a monitor pops one entry per observed change of the DUT outputs.
module tb_operand_loader;

  localparam int DB = 4;
`ifdef LOADER_DEBOUNCE_EN
  localparam int LAT = DB + 2;
`else
  localparam int LAT = 3;
`endif

  logic        Clk;
  logic        Reset_Clear;
  logic        Enter;
  logic [3:0]  SW;
  logic        Cancel;
  logic        Ready;
  logic [15:0] Data_Out;
  logic        Valid;
  logic [15:0] Entry;
  logic [2:0]  Digit_Cnt;

  operand_loader #(.DEBOUNCE_CYCLES(16'(DB))) dut (
    .Clk         (Clk),
    .Reset_Clear (Reset_Clear),
    .Enter       (Enter),
    .SW          (SW),
    .Cancel      (Cancel),
    .Ready       (Ready),
    .Data_Out    (Data_Out),
    .Valid       (Valid),
    .Entry       (Entry),
    .Digit_Cnt   (Digit_Cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [35:0] val;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  int n_pass  = 0;
  int n_total = 0;
  bit mon_en  = 1'b0;

  logic [15:0] m_entry = '0;
  logic [2:0]  m_cnt   = '0;
  logic [15:0] m_data  = '0;
  logic        m_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  function automatic void push(input string name, input int at);
    exp_t e;
    e.name = name;
    e.val  = {m_data, m_valid, m_entry, m_cnt};
    e.cyc  = at;
    sb.push_back(e);
  endfunction

  function automatic void exp_press(input logic [3:0] sw, input int at);
    if (!m_valid) begin
      m_entry = {m_entry[11:0], sw};
      m_cnt   = m_cnt + 3'd1;
      if (m_cnt == 3'd4) begin
        m_data  = m_entry;
        m_valid = 1'b1;
      end
      push("press", at);
    end
  endfunction

  function automatic void model_clear();
    m_entry = '0;
    m_cnt   = '0;
  endfunction

  function automatic logic [35:0] snap();
    return {Data_Out, Valid, Entry, Digit_Cnt};
  endfunction

  task automatic compare_next(input logic [35:0] cur);
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_change: actual=%0h required=no change (cycle %0d)", cur, cyc);
    end else begin
      e = sb.pop_front();
      check(e.name, cur, e.val);
      check({e.name, "_cycle"}, cyc, e.cyc);
    end
  endtask

  initial begin : monitor
    logic [35:0] cur, last;
    wait (mon_en);
    #1;
    cur = snap();
    compare_next(cur);
    last = cur;
    forever begin
      @(negedge Clk or negedge Reset_Clear);
      #1;
      cur = snap();
      if (cur !== last) begin
        compare_next(cur);
        last = cur;
      end
    end
  end

  task automatic press(input logic [3:0] sw);
    @(negedge Clk);
    SW    = sw;
    Enter = 1'b0;
    exp_press(sw, cyc + LAT);
    repeat (LAT + 2) @(negedge Clk);
    Enter = 1'b1;
    repeat (LAT + 3) @(negedge Clk);
  endtask

  task automatic handshake();
    @(negedge Clk);
    Ready = 1'b1;
    if (m_valid) begin
      m_valid = 1'b0;
      model_clear();
      push("handshake", cyc + 1);
    end
    @(negedge Clk);
    Ready = 1'b0;
  endtask

  task automatic cancel_only();
    @(negedge Clk);
    Cancel = 1'b1;
    if (!m_valid && (m_cnt != 3'd0 || m_entry != 16'd0)) begin
      model_clear();
      push("cancel", cyc + 1);
    end
    @(negedge Clk);
    Cancel = 1'b0;
  endtask

  task automatic cancel_press(input logic [3:0] sw);
    int k;
    @(negedge Clk);
    SW    = sw;
    Enter = 1'b0;
    k     = cyc;
    repeat (LAT - 1) @(negedge Clk);
    Cancel = 1'b1;
    if (!m_valid) begin
      model_clear();
      push("cancel_with_press", k + LAT);
    end
    @(negedge Clk);
    Cancel = 1'b0;
    repeat (2) @(negedge Clk);
    Enter = 1'b1;
    repeat (LAT + 3) @(negedge Clk);
  endtask

  task automatic bounce(input logic [3:0] sw);
    @(negedge Clk);
    SW = sw;
    for (int i = 0; i < 10; i++) begin
      Enter = (i % 2 == 1);
`ifndef LOADER_DEBOUNCE_EN
      if (i % 2 == 0) exp_press(sw, cyc + LAT);
`endif
      repeat (2) @(negedge Clk);
    end
    Enter = 1'b0;
    exp_press(sw, cyc + LAT);
    repeat (LAT + 2) @(negedge Clk);
    Enter = 1'b1;
    repeat (LAT + 3) @(negedge Clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    Reset_Clear = 1'b0;
    Enter       = 1'b1;
    SW          = 4'h0;
    Cancel      = 1'b0;
    Ready       = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_Clear = 1'b1;
    push("reset_state", cyc);
    mon_en = 1'b1;
    repeat (5) @(negedge Clk);

    press(4'h1);
    press(4'h2);
    press(4'h3);
    press(4'h4);

    repeat (10) @(negedge Clk);
    press(4'hF);
    check("offer_hold_data", Data_Out, 16'h1234);
    check("offer_hold_valid", Valid, 1'b1);
    handshake();

    @(negedge Clk);
    Ready = 1'b1;
    repeat (3) @(negedge Clk);
    Ready = 1'b0;

    bounce(4'hA);
    if (m_valid) handshake();
    else cancel_only();

    press(4'h7);
    press(4'h8);
    cancel_press(4'h9);

    press(4'hC);
    press(4'hA);
    press(4'hF);
    press(4'hE);
    @(negedge Clk);
    Cancel = 1'b1;
    repeat (5) @(negedge Clk);
    check("cancel_in_offer_valid", Valid, 1'b1);
    check("cancel_in_offer_entry", Entry, 16'hCAFE);
    Cancel = 1'b0;
    handshake();

    press(4'hB);
    press(4'hE);
    press(4'hE);
    press(4'hF);
    @(negedge Clk);
    Enter = 1'b0;
    repeat (5) @(negedge Clk);
    #2;
    Reset_Clear = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    model_clear();
    push("reset_in_offer", cyc);
    #1;
    check("reset_immediate", {Data_Out, Valid, Entry, Digit_Cnt}, 36'd0);
    repeat (2) @(negedge Clk);
    Reset_Clear = 1'b1;
    repeat (20) @(negedge Clk);
    Enter = 1'b1;
    repeat (LAT + 3) @(negedge Clk);
    press(4'h5);

    repeat (5) @(negedge Clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
